aes128_iter_stream: RTL and testbench

// Iterative AES-128 encryption core with parametrised-width beat-serial I/O and valid/ready handshakes.

---
 rtl/aes128_iter_stream.sv | 178 +++++++++++++++++
 tb/tb_aes128_iter_stream.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_stream.sv
// Iterative AES-128 encryptor with IO_W-bit beat-serial load/unload, on-the-fly key expansion and key reuse.
// Latency: 11 cycles from the last input beat to the first output beat; in_ready held low and state_out held stable while unloading is stalled.
module aes128_iter_stream #(
    parameter int IO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            key_load,
    input  logic [IO_W-1:0] key_in,
    input  logic [IO_W-1:0] state_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IO_W-1:0] state_out,
    output logic            busy
);
    localparam int BEATS = 128 / IO_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {LOAD, ROUND, UNLOAD} fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [CW-1:0]   beat_cnt;
    logic [3:0]      round_cnt;
    logic [127:0]    state_q, key_q, rk_q;
    logic [127:0]    round_out, rk_next;
    logic            kl_q, kl_eff, last_beat, in_xfer, out_xfer;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x12, t, inv;
        x2  = gmul(a, a);
        x3  = gmul(x2, a);
        x12 = gmul(gmul(x3, x3), gmul(x3, x3));
        t   = gmul(x12, x3);
        for (int i = 0; i < 4; i++) t = gmul(t, t);
        inv = gmul(gmul(t, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign in_ready  = (fsm_q == LOAD) && enable && !rst;
    assign out_valid = (fsm_q == UNLOAD) && enable && !rst;
    assign busy      = (fsm_q == ROUND) || (fsm_q == UNLOAD);
    assign state_out = (fsm_q == UNLOAD) ? state_q[127-IO_W*int'(beat_cnt) -: IO_W] : '0;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_beat = (beat_cnt == CW'(BEATS - 1));
    // key_load is only meaningful on beat 0; later beats follow the latched choice.
    assign kl_eff    = (beat_cnt == '0) ? key_load : kl_q;

    always_comb begin
        rk_next   = key_q;
        round_out = state_q ^ key_q;
        if (round_cnt != 4'd0) begin
            rk_next   = key_step(rk_q, rcon(round_cnt));
            round_out = (round_cnt == 4'd10) ? sub_shift(state_q) ^ rk_next
                                             : mix_cols(sub_shift(state_q)) ^ rk_next;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            LOAD:    if (in_xfer && last_beat) fsm_d = ROUND;
            ROUND:   if (round_cnt == 4'd10) fsm_d = UNLOAD;
            UNLOAD:  if (out_xfer && last_beat) fsm_d = LOAD;
            default: fsm_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         fsm_q <= LOAD;
        else if (enable) fsm_q <= fsm_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            round_cnt <= 4'd0;
            state_q   <= '0;
            key_q     <= '0;
            rk_q      <= '0;
            kl_q      <= 1'b0;
        end else if (enable) begin
            case (fsm_q)
                LOAD: if (in_xfer) begin
                    state_q[127-IO_W*int'(beat_cnt) -: IO_W] <= state_in;
                    if (kl_eff) key_q[127-IO_W*int'(beat_cnt) -: IO_W] <= key_in;
                    if (beat_cnt == '0) kl_q <= key_load;
                    beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
                    round_cnt <= 4'd0;
                end
                ROUND: begin
                    state_q <= round_out;
                    rk_q    <= rk_next;
                    if (round_cnt == 4'd10) begin
                        round_cnt <= 4'd0;
                        beat_cnt  <= '0;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                UNLOAD: if (out_xfer) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_iter_stream.sv
// Directed-vector bench for aes128_iter_stream: an 8-bit and a 32-bit instance against FIPS-197 vectors.
module tb_aes128_iter_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable;
    logic        in_valid, in_ready, key_load, out_valid, out_ready, busy;
    logic [7:0]  key_in, state_in, state_out;
    logic        in_valid_w, in_ready_w, key_load_w, out_valid_w, out_ready_w, busy_w;
    logic [31:0] key_in_w, state_in_w, state_out_w;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int last_acc = 0;
    int first_out = 0;

    logic [127:0] key1, pt1, ct1, key2, pt2, ct2, ones, zero, ctz, ct;

    always @(posedge clk) cyc <= cyc + 1;

    aes128_iter_stream #(.IO_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .key_load(key_load),
        .key_in(key_in), .state_in(state_in),
        .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out), .busy(busy)
    );

    aes128_iter_stream #(.IO_W(32)) dut_w (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .key_load(key_load_w),
        .key_in(key_in_w), .state_in(state_in_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .state_out(state_out_w), .busy(busy_w)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_in_ready();
        int t = 0;
        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send_block(input logic [127:0] key, input logic [127:0] pt,
                              input logic kl, input bit gaps);
        for (int b = 0; b < 16; b++) begin
            if (gaps) begin
                in_valid = 1'b0;
                key_in   = 8'($urandom);
                state_in = 8'($urandom);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            key_load = kl;
            key_in   = key[127-8*b -: 8];
            state_in = pt[127-8*b -: 8];
            wait_in_ready();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        key_load = 1'b0;
        last_acc = cyc;
    endtask

    task automatic recv_block(output logic [127:0] res, input int hold_beat);
        int t;
        logic [7:0] held;
        bit stable;
        res = '0;
        for (int b = 0; b < 16; b++) begin
            out_ready = (b != hold_beat);
            t = 0;
            while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
            if (!out_valid) begin
                chk("out_valid_timeout", 0, 1);
                out_ready = 1'b0;
                return;
            end
            if (b == 0) first_out = cyc;
            if (b == hold_beat) begin
                held = state_out;
                stable = 1'b1;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (state_out !== held || !out_valid || in_ready) stable = 1'b0;
                end
                chk("bp_hold_stable", 128'(stable), 1);
                out_ready = 1'b1;
            end
            res[127-8*b -: 8] = state_out;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        key1 = 128'h000102030405060708090a0b0c0d0e0f;
        pt1  = 128'h00112233445566778899aabbccddeeff;
        ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pt2  = 128'h3243f6a8885a308d313198a2e0370734;
        ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
        ones = '1;
        zero = '0;
        ctz  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

        rst = 1'b1; enable = 1'b1;
        in_valid = 1'b0; key_load = 1'b0; key_in = '0; state_in = '0; out_ready = 1'b0;
        in_valid_w = 1'b0; key_load_w = 1'b0; key_in_w = '0; state_in_w = '0; out_ready_w = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 0);
        chk("rst_out_valid", 128'(out_valid), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_state_out", 128'(state_out), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 1);

        // 32-bit instance: four beats in, four beats out
        for (int b = 0; b < 4; b++) begin
            in_valid_w = 1'b1;
            key_load_w = 1'b1;
            key_in_w   = key2[127-32*b -: 32];
            state_in_w = pt2[127-32*b -: 32];
            t = 0;
            while (!in_ready_w && t < 200) begin @(posedge clk); #1; t++; end
            if (!in_ready_w) chk("w32_in_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid_w = 1'b0;
        out_ready_w = 1'b1;
        ct = '0;
        for (int b = 0; b < 4; b++) begin
            t = 0;
            while (!out_valid_w && t < 200) begin @(posedge clk); #1; t++; end
            if (!out_valid_w) chk("w32_out_timeout", 0, 1);
            ct[127-32*b -: 32] = state_out_w;
            @(posedge clk); #1;
        end
        out_ready_w = 1'b0;
        chk("w32_ct", ct, ct2);
        chk("w32_idle_busy", 128'(busy_w), 0);

        // 8-bit FIPS-197 appendix C.1 vector, with latency and handover checks
        send_block(key1, pt1, 1'b1, 1'b0);
        chk("round_busy", 128'(busy), 1);
        chk("round_in_ready", 128'(in_ready), 0);
        recv_block(ct, -1);
        chk("v1_ct", ct, ct1);
        chk("v1_latency", 128'(first_out - last_acc), 11);
        chk("v1_out_valid_drop", 128'(out_valid), 0);
        chk("v1_in_ready_rise", 128'(in_ready), 1);

        // stored key reused; key_in carries junk
        send_block(ones, pt1, 1'b0, 1'b0);
        recv_block(ct, -1);
        chk("reuse_ct", ct, ct1);

        // new key with input gaps, sink stalls 10 cycles on beat 5
        send_block(key2, pt2, 1'b1, 1'b1);
        recv_block(ct, 5);
        chk("gaps_bp_ct", ct, ct2);

        // enable dropped for 5 cycles while round_cnt is 4
        send_block(key1, pt1, 1'b1, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        enable = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("stall_out_valid", 128'(out_valid), 0);
        enable = 1'b1;
        recv_block(ct, -1);
        chk("stall_ct", ct, ct1);
        chk("stall_latency", 128'(first_out - last_acc), 16);

        // reset at round_cnt 6 discards the block and clears the stored key
        send_block(key1, pt1, 1'b1, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 0);
        chk("midrst_busy", 128'(busy), 0);
        chk("midrst_in_ready", 128'(in_ready), 1);
        send_block(ones, zero, 1'b0, 1'b0);
        recv_block(ct, -1);
        chk("zero_key_ct", ct, ctz);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
